// File: rtl/fc_weight_loader_pkg.sv
// Shared constants, types and state encoding for the fc weight loader and its packer.
package fc_pkg;

    localparam int FC_LANES = 128;
    localparam int FC_DEPTH = 84;
    localparam int FC_PTR_W = 7;
    localparam int FC_IN_W  = 32;

    typedef logic [FC_LANES-1:0][7:0] fc_weight_vec_t;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WRITE,
        LOADED,
        READ,
        DRAIN
    } ld_state_t;

    // Number of stream beats that make up one full row of byte lanes.
    function automatic int fc_beats(input int lanes, input int in_w);
        return (lanes * 8) / in_w;
    endfunction

endpackage

// File: rtl/fc_weight_loader_row_packer.sv
// Row assembly register: merges one stream beat at a time into the LANES-byte row.
module fc_row_packer
    import fc_pkg::*;
#(
    parameter int LANES  = FC_LANES,
    parameter int IN_W   = FC_IN_W,
    parameter int BEAT_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [IN_W-1:0]        beat_data,
    input  logic [BEAT_W-1:0]      beat_idx,
    input  logic                   beat_we,
    output logic [LANES-1:0][7:0]  row_next
);

    localparam int BPB   = IN_W / 8;
    localparam int BEATS = fc_beats(LANES, IN_W);

    logic [LANES-1:0][7:0] row_q;

    // row_next already contains the beat being accepted, so the completed row
    // can be captured on the same edge as its final beat.
    always_comb begin
        row_next = row_q;
        if (beat_we) begin
            for (int b = 0; b < BEATS; b++) begin
                if (beat_idx == BEAT_W'(b)) begin
                    for (int k = 0; k < BPB; k++) begin
                        row_next[b*BPB + k] = beat_data[8*k +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
        end else if (beat_we) begin
            row_q <= row_next;
        end
    end

endmodule

// File: rtl/fc_weight_loader.sv
// Packs a byte-lane weight stream into buffer rows and sequences the skewed read pass.
module fc_weight_loader
    import fc_pkg::*;
#(
    parameter int LANES = FC_LANES,
    parameter int DEPTH = FC_DEPTH,
    parameter int PTR_W = FC_PTR_W,
    parameter int IN_W  = FC_IN_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [PTR_W-1:0]              num_rows_i,
    input  logic [IN_W-1:0]               s_data_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    input  logic                          rd_start_i,
    output logic                          wren_o,
    output logic [LANES-1:0][PTR_W-1:0]   wrptr_o,
    output logic [LANES-1:0][7:0]         weight_o,
    output logic                          rden_o,
    output logic [PTR_W-1:0]              rdptr_o,
    output logic                          load_done_o,
    output logic                          rd_done_o,
    output logic                          busy_o
);

    localparam int BEATS  = fc_beats(LANES, IN_W);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DRN_W  = (LANES > 2) ? $clog2(LANES) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [DRN_W-1:0]  DRAIN_LAST = DRN_W'(LANES - 2);
    localparam logic [PTR_W-1:0]  MAX_ROWS   = PTR_W'(DEPTH);

    ld_state_t              state;
    logic [PTR_W-1:0]       rows;
    logic [PTR_W-1:0]       row_cnt;
    logic [PTR_W-1:0]       rd_cnt;
    logic [BEAT_W-1:0]      beat_cnt;
    logic [DRN_W-1:0]       drain_cnt;
    logic [LANES-1:0][7:0]  row_next;
    logic                   hs;
    logic                   start_ok;
    logic [PTR_W-1:0]       rows_clamped;

    assign hs           = (state == FILL) && s_valid_i && s_ready_o;
    assign start_ok     = start_i && (num_rows_i != '0);
    assign rows_clamped = (num_rows_i > MAX_ROWS) ? MAX_ROWS : num_rows_i;

    fc_row_packer #(
        .LANES  (LANES),
        .IN_W   (IN_W),
        .BEAT_W (BEAT_W)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .beat_data (s_data_i),
        .beat_idx  (beat_cnt),
        .beat_we   (hs),
        .row_next  (row_next)
    );

    // wren_o and rd_done_o are single-cycle strobes; every other output is
    // driven alongside the state transition that owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rows        <= '0;
            row_cnt     <= '0;
            rd_cnt      <= '0;
            beat_cnt    <= '0;
            drain_cnt   <= '0;
            s_ready_o   <= 1'b0;
            wren_o      <= 1'b0;
            wrptr_o     <= '0;
            weight_o    <= '0;
            rden_o      <= 1'b0;
            rdptr_o     <= '0;
            load_done_o <= 1'b0;
            rd_done_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            wren_o    <= 1'b0;
            rd_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        rows      <= rows_clamped;
                        row_cnt   <= '0;
                        beat_cnt  <= '0;
                        s_ready_o <= 1'b1;
                        busy_o    <= 1'b1;
                        state     <= FILL;
                    end
                end

                FILL: begin
                    if (hs) begin
                        if (beat_cnt == LAST_BEAT) begin
                            s_ready_o <= 1'b0;
                            wren_o    <= 1'b1;
                            wrptr_o   <= {LANES{row_cnt}};
                            weight_o  <= row_next;
                            state     <= WRITE;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end
                end

                // row_cnt stays on the final row index so it never exceeds DEPTH-1.
                WRITE: begin
                    beat_cnt <= '0;
                    if ((row_cnt + PTR_W'(1)) == rows) begin
                        load_done_o <= 1'b1;
                        busy_o      <= 1'b0;
                        state       <= LOADED;
                    end else begin
                        row_cnt   <= row_cnt + PTR_W'(1);
                        s_ready_o <= 1'b1;
                        state     <= FILL;
                    end
                end

                LOADED: begin
                    if (start_ok) begin
                        rows        <= rows_clamped;
                        row_cnt     <= '0;
                        beat_cnt    <= '0;
                        load_done_o <= 1'b0;
                        s_ready_o   <= 1'b1;
                        busy_o      <= 1'b1;
                        state       <= FILL;
                    end else if (rd_start_i) begin
                        rd_cnt  <= '0;
                        rden_o  <= 1'b1;
                        rdptr_o <= '0;
                        busy_o  <= 1'b1;
                        state   <= READ;
                    end
                end

                READ: begin
                    if (rd_cnt == (rows - PTR_W'(1))) begin
                        rden_o    <= 1'b0;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        rd_cnt  <= rd_cnt + PTR_W'(1);
                        rdptr_o <= rd_cnt + PTR_W'(1);
                    end
                end

                // The buffer delays lane n by n cycles, so the last lane's read
                // issues LANES-1 cycles after the final address.
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        rd_done_o <= 1'b1;
                        busy_o    <= 1'b0;
                        state     <= LOADED;
                    end else begin
                        drain_cnt <= drain_cnt + DRN_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_weight_loader.sv
// Directed self-checking bench for fc_weight_loader: row packing, back-pressure, read pass timing and reset.
module tb_fc_weight_loader;
    import fc_pkg::*;

    localparam int LANES = FC_LANES;
    localparam int DEPTH = FC_DEPTH;
    localparam int PTR_W = FC_PTR_W;
    localparam int IN_W  = FC_IN_W;
    localparam int BEATS = LANES * 8 / IN_W;
    localparam int BPB   = IN_W / 8;

    logic                         clk;
    logic                         rst_n;
    logic                         start_i;
    logic [PTR_W-1:0]             num_rows_i;
    logic [IN_W-1:0]              s_data_i;
    logic                         s_valid_i;
    logic                         s_ready_o;
    logic                         rd_start_i;
    logic                         wren_o;
    logic [LANES-1:0][PTR_W-1:0]  wrptr_o;
    fc_weight_vec_t               weight_o;
    logic                         rden_o;
    logic [PTR_W-1:0]             rdptr_o;
    logic                         load_done_o;
    logic                         rd_done_o;
    logic                         busy_o;

    fc_weight_loader #(
        .LANES (LANES),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .IN_W  (IN_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .num_rows_i  (num_rows_i),
        .s_data_i    (s_data_i),
        .s_valid_i   (s_valid_i),
        .s_ready_o   (s_ready_o),
        .rd_start_i  (rd_start_i),
        .wren_o      (wren_o),
        .wrptr_o     (wrptr_o),
        .weight_o    (weight_o),
        .rden_o      (rden_o),
        .rdptr_o     (rdptr_o),
        .load_done_o (load_done_o),
        .rd_done_o   (rd_done_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int num_checks = 0;
    int num_errors = 0;

    logic [7:0]       exp_mem [0:DEPTH-1][0:LANES-1];
    int               wr_count = 0;
    int               wr_base  = 0;
    int               wr_cyc   [0:255];
    logic [PTR_W-1:0] wr_ptr   [0:255];
    logic [7:0]       wr_b5    [0:255];
    logic [7:0]       wr_b127  [0:255];

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Every write is compared against the bench's own row table, indexed by
    // the number of writes seen since the last accepted start.
    always @(negedge clk) begin : wr_monitor
        int idx;
        int bad_data;
        int bad_ptr;
        if (rst_n) begin
            if (wren_o || rden_o)
                checkOutput("wren_rden_exclusive", 64'(wren_o & rden_o), 64'd0);
            if (wren_o) begin
                idx      = wr_count - wr_base;
                bad_data = 0;
                bad_ptr  = 0;
                if (idx < DEPTH) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (weight_o[l] !== exp_mem[idx][l]) bad_data++;
                        if (wrptr_o[l] !== PTR_W'(idx)) bad_ptr++;
                    end
                    checkOutput("wrptr", 64'(wrptr_o[0]), 64'(idx));
                    checkOutput("wrptr_lanes_bad", 64'(bad_ptr), 64'd0);
                    checkOutput("row_bytes_bad", 64'(bad_data), 64'd0);
                end else begin
                    checkOutput("write_beyond_depth", 64'(idx), 64'(DEPTH - 1));
                end
                wr_cyc[wr_count & 255]  = cyc;
                wr_ptr[wr_count & 255]  = wrptr_o[0];
                wr_b5[wr_count & 255]   = weight_o[5];
                wr_b127[wr_count & 255] = weight_o[127];
                wr_count++;
            end
        end
    end

    task automatic applyStimulus(input logic st, input logic [PTR_W-1:0] nr, input logic rs);
        start_i    = st;
        num_rows_i = nr;
        rd_start_i = rs;
        @(negedge clk);
        start_i    = 1'b0;
        rd_start_i = 1'b0;
    endtask

    task automatic sendBeat(input int r, input int b, input int max_gap);
        int gap;
        int waited;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin
            s_valid_i = 1'b0;
            @(negedge clk);
        end
        for (int k = 0; k < BPB; k++) s_data_i[8*k +: 8] = exp_mem[r][b*BPB + k];
        s_valid_i = 1'b1;
        waited = 0;
        while (!s_ready_o && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready_o) begin
            checkOutput("beat_accept_timeout", 64'd1, 64'd0);
            s_valid_i = 1'b0;
            return;
        end
        @(negedge clk);
    endtask

    task automatic feedRows(input int n, input int max_gap);
        for (int r = 0; r < n; r++)
            for (int b = 0; b < BEATS; b++)
                sendBeat(r, b, max_gap);
        s_valid_i = 1'b0;
    endtask

    task automatic waitLoadDone(output int done_cyc);
        int n;
        n = 0;
        while (!load_done_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("load_done_rise", 64'(load_done_o), 64'd1);
        done_cyc = cyc;
    endtask

    task automatic readPass(input int nrows);
        int first;
        int last;
        int len;
        int ptr_bad;
        int done_cyc;
        int done_cnt;
        int w0;
        first = -1; last = -1; len = 0; ptr_bad = 0;
        done_cyc = -1; done_cnt = 0; w0 = wr_count;
        applyStimulus(1'b0, '0, 1'b1);
        for (int i = 0; i < nrows + LANES + 20; i++) begin
            if (rden_o) begin
                if (first < 0) first = cyc;
                last = cyc;
                if (rdptr_o !== PTR_W'(len)) ptr_bad++;
                len++;
            end
            if (rd_done_o) begin
                if (done_cyc < 0) done_cyc = cyc;
                done_cnt++;
            end
            @(negedge clk);
        end
        checkOutput("rden_cycles", 64'(len), 64'(nrows));
        checkOutput("rden_contiguous", 64'(last - first + 1), 64'(nrows));
        checkOutput("rdptr_bad", 64'(ptr_bad), 64'd0);
        checkOutput("rd_done_latency", 64'(done_cyc - first), 64'(nrows + LANES - 1));
        checkOutput("rd_done_pulses", 64'(done_cnt), 64'd1);
        checkOutput("no_write_in_read", 64'(wr_count - w0), 64'd0);
        checkOutput("load_done_after_read", 64'(load_done_o), 64'd1);
        checkOutput("busy_after_read", 64'(busy_o), 64'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int b;
        int ld_cyc;
        int rden_hits;
        int nz;

        rst_n      = 1'b0;
        start_i    = 1'b0;
        num_rows_i = '0;
        s_data_i   = '0;
        s_valid_i  = 1'b0;
        rd_start_i = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        nz = 0;
        for (int l = 0; l < LANES; l++) if (weight_o[l] !== 8'h00) nz++;
        checkOutput("rst_s_ready", 64'(s_ready_o), 64'd0);
        checkOutput("rst_wren", 64'(wren_o), 64'd0);
        checkOutput("rst_rden", 64'(rden_o), 64'd0);
        checkOutput("rst_load_done", 64'(load_done_o), 64'd0);
        checkOutput("rst_busy", 64'(busy_o), 64'd0);
        checkOutput("rst_weight_nonzero", 64'(nz), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // rd_start_i in IDLE is ignored
        applyStimulus(1'b0, '0, 1'b1);
        rden_hits = 0;
        repeat (5) begin
            if (rden_o) rden_hits++;
            @(negedge clk);
        end
        checkOutput("idle_rd_start_rden", 64'(rden_hits), 64'd0);
        checkOutput("idle_rd_start_busy", 64'(busy_o), 64'd0);

        // start_i with zero rows is ignored
        applyStimulus(1'b1, '0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("zero_rows_busy", 64'(busy_o), 64'd0);
        checkOutput("zero_rows_ready", 64'(s_ready_o), 64'd0);

        // Two rows, back-to-back beats
        for (int r = 0; r < 2; r++)
            for (int l = 0; l < LANES; l++) exp_mem[r][l] = 8'(r * 8'h80 + l);
        wr_base = wr_count;
        b = wr_count;
        applyStimulus(1'b1, PTR_W'(2), 1'b0);
        checkOutput("t1_ready_in_fill", 64'(s_ready_o), 64'd1);
        checkOutput("t1_busy_in_fill", 64'(busy_o), 64'd1);
        feedRows(2, 0);
        waitLoadDone(ld_cyc);
        checkOutput("t1_write_count", 64'(wr_count - wr_base), 64'd2);
        checkOutput("t1_write_spacing", 64'(wr_cyc[b+1] - wr_cyc[b]), 64'd33);
        checkOutput("t1_wrptr0", 64'(wr_ptr[b]), 64'd0);
        checkOutput("t1_wrptr1", 64'(wr_ptr[b+1]), 64'd1);
        checkOutput("t1_lane5_row0", 64'(wr_b5[b]), 64'h05);
        checkOutput("t1_lane5_row1", 64'(wr_b5[b+1]), 64'h85);
        checkOutput("t1_lane127_row0", 64'(wr_b127[b]), 64'h7F);
        checkOutput("t1_lane127_row1", 64'(wr_b127[b+1]), 64'hFF);
        checkOutput("t1_load_done_cycle", 64'(ld_cyc - wr_cyc[b+1]), 64'd1);
        checkOutput("t1_ready_in_loaded", 64'(s_ready_o), 64'd0);

        // Random gaps and a source holding its beat across WRITE
        for (int r = 0; r < 4; r++)
            for (int l = 0; l < LANES; l++) exp_mem[r][l] = 8'($urandom);
        wr_base = wr_count;
        applyStimulus(1'b1, PTR_W'(4), 1'b0);
        checkOutput("t2_reload_ready", 64'(s_ready_o), 64'd1);
        checkOutput("t2_reload_clears_done", 64'(load_done_o), 64'd0);
        feedRows(4, 3);
        waitLoadDone(ld_cyc);
        checkOutput("t2_write_count", 64'(wr_count - wr_base), 64'd4);

        // Oversized row count clamps to DEPTH
        for (int r = 0; r < DEPTH; r++)
            for (int l = 0; l < LANES; l++) exp_mem[r][l] = 8'(r * 3 + l * 5 + 1);
        wr_base = wr_count;
        b = wr_count;
        applyStimulus(1'b1, PTR_W'(100), 1'b0);
        feedRows(DEPTH, 0);
        waitLoadDone(ld_cyc);
        checkOutput("t4_write_count", 64'(wr_count - wr_base), 64'(DEPTH));
        checkOutput("t4_last_wrptr", 64'(wr_ptr[(b + DEPTH - 1) & 255]), 64'(DEPTH - 1));
        checkOutput("t4_wrptr_held", 64'(wrptr_o[0]), 64'(DEPTH - 1));

        // Two identical read passes over all rows
        readPass(DEPTH);
        readPass(DEPTH);

        // start_i beats rd_start_i in LOADED
        for (int l = 0; l < LANES; l++) exp_mem[0][l] = 8'(l ^ 8'h5A);
        wr_base = wr_count;
        applyStimulus(1'b1, PTR_W'(3), 1'b1);
        checkOutput("t6_ready", 64'(s_ready_o), 64'd1);
        checkOutput("t6_load_done", 64'(load_done_o), 64'd0);
        checkOutput("t6_busy", 64'(busy_o), 64'd1);
        rden_hits = 0;
        repeat (5) begin
            if (rden_o) rden_hits++;
            @(negedge clk);
        end
        checkOutput("t6_rden_stays_low", 64'(rden_hits), 64'd0);

        // Asynchronous reset part-way through a row
        for (int bb = 0; bb < 10; bb++) sendBeat(0, bb, 0);
        #2;
        rst_n = 1'b0;
        #1;
        nz = 0;
        for (int l = 0; l < LANES; l++) if (weight_o[l] !== 8'h00) nz++;
        checkOutput("t5_rst_s_ready", 64'(s_ready_o), 64'd0);
        checkOutput("t5_rst_busy", 64'(busy_o), 64'd0);
        checkOutput("t5_rst_wren", 64'(wren_o), 64'd0);
        checkOutput("t5_rst_rden", 64'(rden_o), 64'd0);
        checkOutput("t5_rst_load_done", 64'(load_done_o), 64'd0);
        checkOutput("t5_rst_rd_done", 64'(rd_done_o), 64'd0);
        checkOutput("t5_rst_rdptr", 64'(rdptr_o), 64'd0);
        checkOutput("t5_rst_wrptr", 64'(wrptr_o[0]), 64'd0);
        checkOutput("t5_rst_weight_nonzero", 64'(nz), 64'd0);
        s_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int l = 0; l < LANES; l++) exp_mem[0][l] = 8'(l ^ 8'hC3);
        wr_base = wr_count;
        applyStimulus(1'b1, PTR_W'(1), 1'b0);
        feedRows(1, 0);
        waitLoadDone(ld_cyc);
        checkOutput("t5_write_count", 64'(wr_count - wr_base), 64'd1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
